// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Converts an unsigned BIN_W-bit value into eight BCD digits for an 8-digit
// multiplexed 7-segment driver. Digit outputs only change in the single done
// cycle, so the display stays stable while a conversion runs. Values above
// 99,999,999 are shown as "FFFFFFFF" with overflow raised.
module bin2bcd_seq #(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3,
    output logic [3:0]       digit4,
    output logic [3:0]       digit5,
    output logic [3:0]       digit6,
    output logic [3:0]       digit7
);

    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [26:0] BCD_MAX = 27'd99_999_999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;     // start taken this cycle (IDLE or DONE)
    logic             finish;     // last shift done, publish result
    logic [BIN_W-1:0] sr;         // binary bits still to be shifted in
    logic [31:0]      acc;        // eight BCD nibbles being built
    logic [31:0]      acc_adj;    // acc after the add-3 correction
    logic [CNT_W-1:0] count;      // shifts remaining
    logic             ovf_q;      // captured value exceeds 8 digits
    logic [31:0]      dig_q;      // displayed digits, held between conversions
    logic [26:0]      bin_ext;    // bin_in zero-extended to the 27-bit compare width

    assign bin_ext = 27'(bin_in);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // One extra SHIFT cycle with count==0 publishes the result,
                // placing done at accept edge + BIN_W + 1.
                if (count == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble in parallel before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: shift register and BCD accumulator.
    always_ff @(posedge clk) begin
        // NOTE: sr/acc carry no reset; they are always reloaded on accept before being used.
        if (accept) begin
            sr  <= bin_in;
            acc <= '0;
        end else if (state == SHIFT && count != '0) begin
            acc <= (acc_adj << 1) | 32'(sr[BIN_W-1]);
            sr  <= sr << 1;
        end
    end

    // Control counters and the held display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            ovf_q    <= 1'b0;
            dig_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                count <= CNT_W'(BIN_W);
                ovf_q <= (bin_ext > BCD_MAX);
            end else if (state == SHIFT && count != '0) begin
                count <= count - CNT_W'(1);
            end
            if (finish) begin
                dig_q    <= ovf_q ? 32'hFFFF_FFFF : acc;
                overflow <= ovf_q;
            end
        end
    end

    assign digit0 = dig_q[3:0];
    assign digit1 = dig_q[7:4];
    assign digit2 = dig_q[11:8];
    assign digit3 = dig_q[15:12];
    assign digit4 = dig_q[19:16];
    assign digit5 = dig_q[23:20];
    assign digit6 = dig_q[27:24];
    assign digit7 = dig_q[31:28];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq. A cycle-level reference model
// (a countdown timer plus decimal arithmetic) predicts busy/done/overflow/digits
// every cycle; hand-computed literals pin the model on each directed vector.
module tb_bin2bcd_seq;

    localparam int BIN_W = 27;
    localparam int LAT   = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy, done, overflow;
    logic [3:0]       digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4),
        .digit5   (digit5),
        .digit6   (digit6),
        .digit7   (digit7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] digits_now();
        return {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};
    endfunction

    // Expected display for a value: decimal digits, or all F above 8 digits.
    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v > 32'd99_999_999) return 32'hFFFF_FFFF;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_rem counts cycles left until done (0 = ready for start).
    int unsigned m_rem  = 0;
    int unsigned pend   = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [31:0] m_dig  = '0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        chk_en <= 1'b1;
        if (rst) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_dig  <= '0;
        end else begin
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_dig <= to_bcd(pend);
                m_ovf <= (pend > 32'd99_999_999);
            end
            if (m_rem == 0 && start) begin
                pend   <= 32'(bin_in);
                m_rem  <= LAT;
                m_busy <= 1'b1;
            end else if (m_rem != 0) begin
                m_rem  <= m_rem - 1;
                m_busy <= (m_rem > 1);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy",     32'(busy),     32'(m_busy));
            check("cyc done",     32'(done),     32'(m_done));
            check("cyc overflow", 32'(overflow), 32'(m_ovf));
            check("cyc digits",   digits_now(),  m_dig);
        end
    end

    // Wait for done, counting falling edges; bounded so a stuck DUT still ends.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 100);
    endtask

    task automatic do_convert(input int unsigned v, input logic [31:0] exp_dig,
                              input logic exp_ovf, input string nm);
        int k;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v[BIN_W-1:0];
        @(negedge clk);
        start  = 1'b0;
        bin_in = 27'h5A5_A5A5;
        wait_done(k);
        check({nm, " latency"},  32'(k),        32'(LAT));
        check({nm, " digits"},   digits_now(),  exp_dig);
        check({nm, " overflow"}, 32'(overflow), 32'(exp_ovf));
        check({nm, " busy"},     32'(busy),     32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;

        // Reset, then idle with no start.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy",     32'(busy),     32'h0);
        check("reset digits",   digits_now(),  32'h0);
        repeat (5) @(negedge clk);
        check("idle done",      32'(done),     32'h0);
        check("idle overflow",  32'(overflow), 32'h0);
        check("idle digits",    digits_now(),  32'h0);

        // Basic values and the 8-digit boundary.
        do_convert(0,           32'h0000_0000, 1'b0, "zero");
        do_convert(12_345_678,  32'h1234_5678, 1'b0, "12345678");
        do_convert(99_999_999,  32'h9999_9999, 1'b0, "max8");
        do_convert(100_000_000, 32'hFFFF_FFFF, 1'b1, "ovf100M");
        do_convert(5,           32'h0000_0005, 1'b0, "five");
        do_convert(134_217_727, 32'hFFFF_FFFF, 1'b1, "ovfmax");
        do_convert(10_203_040,  32'h1020_3040, 1'b0, "10203040");

        // Start re-pulsed mid-conversion is ignored; then start held through done.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd87_654_321;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 27'd11_111_111;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd42;
        wait_done(k);
        check("ignore latency", 32'(k + 20),   32'(LAT));
        check("ignore digits",  digits_now(),  32'h8765_4321);
        @(negedge clk);
        check("b2b busy",       32'(busy),     32'h1);
        check("b2b done",       32'(done),     32'h0);
        start  = 1'b0;
        bin_in = 27'd999;
        wait_done(k);
        check("b2b latency",    32'(k),        32'(LAT));
        check("b2b digits",     digits_now(),  32'h0000_0042);

        // Reset in the middle of a conversion discards it.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd777;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",    32'(busy),     32'h0);
        check("midrst done",    32'(done),     32'h0);
        check("midrst digits",  digits_now(),  32'h0);
        repeat (LAT + 4) @(negedge clk);
        check("midrst no done", 32'(done),     32'h0);
        do_convert(13_579_246,  32'h1357_9246, 1'b0, "postrst");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
